mem_arbiter: RTL

- Shares one single-port memory between the instruction-fetch requester (I-port) and the load/store requester (D-port).
- Accepts one transaction at a time and issues it to the memory port.
- Waits for the memory's read-valid/ack, then returns a one-cycle response to the owning requester.
- Sits between the fetch/execute stages and the unified memory model; includes a starvation guard and a response timeout.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port (I) and a load/store port (D). One transaction is in flight at a time:
// IDLE (accept) -> ISSUE (one-cycle mem_req) -> WAIT (ack or timeout) -> RESP.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN selects alternating grants
// instead of fixed D priority with the starvation guard.
module mem_arbiter #(
    parameter int unsigned AWIDTH     = 32,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid_i,
    output logic              i_req_ready_o,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_rsp_valid_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_req_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q;
    // Owner of the current/last grant (1 = I). Also serves as last-grant.
    logic              owner_i_q;
    logic              mem_req_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [DWIDTH-1:0] mem_wdata_q;
    logic [TW-1:0]     timer_q;
    logic              i_rsp_q;
    logic              d_rsp_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              d_pick;
    logic              grant_i;
    logic              grant_d;

`ifndef MEM_ARB_ROUND_ROBIN_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX_V = SW'(STARVE_MAX);

    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
`endif

    // Grant selection: at most one ready, only in IDLE and never during reset.
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        d_pick = d_req_valid_i && (!i_req_valid_i || owner_i_q);
`else
        d_pick = d_req_valid_i && (!i_req_valid_i || (starve_q != SMAX_V));
`endif
        grant_d = !rst && (state_q == ST_IDLE) && d_pick;
        grant_i = !rst && (state_q == ST_IDLE) && i_req_valid_i && !d_pick;
        i_req_ready_o = grant_i;
        d_req_ready_o = grant_d;
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Starvation counter next state: count D grants that bypass a waiting I.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d) begin
            if (!i_req_valid_i) begin
                starve_d = '0;
            end else if (starve_q != SMAX_V) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Transaction FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_i_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            timer_q     <= '0;
            i_rsp_q     <= 1'b0;
            d_rsp_q     <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_i) begin
                        owner_i_q   <= 1'b1;
                        mem_addr_q  <= i_addr_i;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'hF;
                        mem_wdata_q <= '0;
                        mem_req_q   <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else if (grant_d) begin
                        owner_i_q   <= 1'b0;
                        mem_addr_q  <= d_addr_i;
                        mem_we_q    <= d_we_i;
                        mem_be_q    <= d_be_i;
                        mem_wdata_q <= d_wdata_i;
                        mem_req_q   <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_req_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        rsp_rdata_q <= mem_we_q ? '0 : mem_rdata_i;
                        rsp_err_q   <= 1'b0;
                        i_rsp_q     <= owner_i_q;
                        d_rsp_q     <= !owner_i_q;
                        state_q     <= ST_RESP;
                    end else if (timer_q == TMO_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        i_rsp_q     <= owner_i_q;
                        d_rsp_q     <= !owner_i_q;
                        state_q     <= ST_RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    i_rsp_q <= 1'b0;
                    d_rsp_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Drive outputs straight from their registers.
    always_comb begin
        mem_req_o     = mem_req_q;
        mem_addr_o    = mem_addr_q;
        mem_we_o      = mem_we_q;
        mem_be_o      = mem_be_q;
        mem_wdata_o   = mem_wdata_q;
        i_rsp_valid_o = i_rsp_q;
        d_rsp_valid_o = d_rsp_q;
        rsp_rdata_o   = rsp_rdata_q;
        rsp_err_o     = rsp_err_q;
    end

endmodule
